ks_pluck_loop: RTL and testbench

Excitation and loop-filter stage of the Karplus-Strong voice, placed directly downstream of the programmable delay line, with its output closing the loop into the delay line's input. On a pluck it injects a burst of LFSR noise one delay-length long. Afterwards it feeds back a decay-scaled two-tap average of the delay line's output. It returns to silence once the loop has decayed to zero.

---
 rtl/ks_pluck_loop.sv | 98 +++++++++
 tb/tb_ks_pluck_loop.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ks_pluck_loop.sv
// rtl/ks_pluck_loop.sv - Karplus-Strong excitation burst and decaying two-tap loop filter
module ks_pluck_loop #(
    parameter logic [23:0] LFSR_SEED = 24'h00ACE1
) (
    input  logic               lrck,
    input  logic               rst_n,
    input  logic               pluck,
    input  logic [9:0]         delay,
    input  logic [7:0]         decay,
    input  logic [2:0]         level,
    input  logic signed [23:0] fb,
    output logic signed [23:0] out,
    output logic               busy,
    output logic               active
);
    typedef enum logic [1:0] {IDLE, EXCITE, RING} state_t;

    state_t             state;
    state_t             state_next;
    logic               pl_d;
    logic               pl_edge;
    logic [9:0]         cnt;
    logic [9:0]         zc;
    logic [9:0]         bl;
    logic signed [23:0] fb_prev;
    logic [23:0]        lfsr;
    logic               lfsr_bit;
    logic signed [24:0] sum;
    logic signed [23:0] avg;
    logic signed [32:0] prod;
    logic signed [23:0] y;
    logic               y_zero;
    logic               burst_last;

    assign pl_edge    = pluck & ~pl_d;
    assign lfsr_bit   = lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16];
    assign burst_last = (cnt == bl - 10'd1);

    // Both divisions truncate toward zero: bias negatives before the arithmetic shift.
    always_comb begin
        sum    = $signed({fb[23], fb}) + $signed({fb_prev[23], fb_prev});
        avg    = 24'((sum + $signed({24'd0, sum[24]})) >>> 1);
        prod   = avg * $signed({1'b0, decay});
        y      = 24'((prod + $signed({25'd0, prod[32] ? 8'hFF : 8'h00})) >>> 8);
        y_zero = (y == 24'sd0);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = IDLE;
            EXCITE:  if (burst_last) state_next = RING;
            RING:    if (y_zero && zc == bl - 10'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (pl_edge) state_next = EXCITE;
    end

    always_ff @(posedge lrck) begin
        if (!rst_n) begin
            state   <= IDLE;
            pl_d    <= 1'b1;
            cnt     <= 10'd0;
            zc      <= 10'd0;
            bl      <= 10'd2;
            fb_prev <= 24'sd0;
            lfsr    <= LFSR_SEED;
            out     <= 24'sd0;
            busy    <= 1'b0;
            active  <= 1'b0;
        end else begin
            state   <= state_next;
            pl_d    <= pluck;
            fb_prev <= fb;
            // Flags describe the sample being written to out this cycle.
            busy    <= (state == EXCITE);
            active  <= (state != IDLE);
            case (state)
                EXCITE: begin
                    out  <= $signed(lfsr) >>> level;
                    lfsr <= {lfsr[22:0], lfsr_bit};
                    cnt  <= cnt + 10'd1;
                    zc   <= 10'd0;
                end
                RING: begin
                    out <= y;
                    zc  <= y_zero ? zc + 10'd1 : 10'd0;
                end
                default: out <= 24'sd0;
            endcase
            if (pl_edge) begin
                cnt <= 10'd0;
                zc  <= 10'd0;
                bl  <= (delay < 10'd2) ? 10'd2 : delay;
            end
        end
    end
endmodule

// File: tb/tb_ks_pluck_loop.sv
// tb/tb_ks_pluck_loop.sv - self-checking bench for ks_pluck_loop
module tb_ks_pluck_loop;
    localparam logic [23:0] SEED = 24'h00ACE1;
    localparam int M_IDLE = 0, M_EXCITE = 1, M_RING = 2;

    logic               lrck = 1'b0;
    logic               rst_n;
    logic               pluck;
    logic [9:0]         delay;
    logic [7:0]         decay;
    logic [2:0]         level;
    logic signed [23:0] fb;
    logic signed [23:0] out;
    logic               busy;
    logic               active;

    int n_checks = 0;
    int n_fails  = 0;

    ks_pluck_loop #(.LFSR_SEED(SEED)) dut (
        .lrck(lrck), .rst_n(rst_n), .pluck(pluck), .delay(delay), .decay(decay),
        .level(level), .fb(fb), .out(out), .busy(busy), .active(active)
    );

    always #5 lrck = ~lrck;

    // Reference model: burst countdown and run of silent outputs, plain integer maths.
    int          m_mode;
    int          m_left;
    int          m_len;
    int          m_quiet;
    bit          m_plprev;
    longint      m_fbprev;
    logic [23:0] m_lfsr;
    longint      e_out;
    bit          e_busy;
    bit          e_active;

    function automatic logic [23:0] lfsr_next(input logic [23:0] v);
        return {v[22:0], v[23] ^ v[22] ^ v[21] ^ v[16]};
    endfunction

    task automatic model_step();
        longint y;
        if (!rst_n) begin
            m_mode = M_IDLE; m_left = 0; m_len = 2; m_quiet = 0;
            m_plprev = 1'b1; m_fbprev = 0; m_lfsr = SEED;
            e_out = 0; e_busy = 1'b0; e_active = 1'b0;
            return;
        end
        e_busy   = (m_mode == M_EXCITE);
        e_active = (m_mode != M_IDLE);
        case (m_mode)
            M_IDLE: e_out = 0;
            M_EXCITE: begin
                e_out  = longint'($signed(m_lfsr)) >>> level;
                m_lfsr = lfsr_next(m_lfsr);
                m_left--;
                if (m_left == 0) begin
                    m_mode  = M_RING;
                    m_quiet = 0;
                end
            end
            default: begin
                y       = (((longint'(fb) + m_fbprev) / 2) * longint'(decay)) / 256;
                e_out   = y;
                m_quiet = (y == 0) ? m_quiet + 1 : 0;
                if (m_quiet == m_len) m_mode = M_IDLE;
            end
        endcase
        if (pluck && !m_plprev) begin
            m_mode = M_EXCITE;
            m_len  = (delay < 2) ? 2 : int'(delay);
            m_left = m_len;
        end
        m_plprev = pluck;
        m_fbprev = longint'(fb);
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge lrck);
        model_step();
        #1;
        check("model_out", longint'(out), e_out);
        check("model_busy", longint'(busy), longint'(e_busy));
        check("model_active", longint'(active), longint'(e_active));
    endtask

    typedef struct {
        bit          rst_n;
        bit          pluck;
        logic [9:0]  delay;
        logic [23:0] out;
        bit          busy;
        bit          active;
    } vec_t;

    vec_t vt[14];

    initial begin
        int nb;
        vt[0]  = '{1'b0, 1'b0, 10'd5, 24'h000000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 10'd5, 24'h000000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b1, 10'd5, 24'h000000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 10'd5, 24'h00ACE1, 1'b1, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 10'd5, 24'h0159C2, 1'b1, 1'b1};
        vt[5]  = '{1'b1, 1'b0, 10'd5, 24'h02B385, 1'b1, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 10'd5, 24'h05670A, 1'b1, 1'b1};
        vt[7]  = '{1'b1, 1'b0, 10'd5, 24'h0ACE15, 1'b1, 1'b1};
        for (int i = 8; i < 13; i++) vt[i] = '{1'b1, 1'b0, 10'd5, 24'h000000, 1'b0, 1'b1};
        vt[13] = '{1'b1, 1'b0, 10'd5, 24'h000000, 1'b0, 1'b0};

        rst_n = 1'b0; pluck = 1'b0; delay = 10'd5; decay = 8'd128; level = 3'd0; fb = 24'sd0;

        // Reset, delay-5 burst from the seed, ring down to idle.
        for (int i = 0; i < 14; i++) begin
            rst_n = vt[i].rst_n; pluck = vt[i].pluck; delay = vt[i].delay;
            @(posedge lrck);
            model_step();
            #1;
            check($sformatf("tbl%0d_out", i), longint'(out), longint'($signed(vt[i].out)));
            check($sformatf("tbl%0d_busy", i), longint'(busy), longint'(vt[i].busy));
            check($sformatf("tbl%0d_active", i), longint'(active), longint'(vt[i].active));
        end

        // delay 0 and 1 both give a two-sample burst.
        for (int d = 0; d < 2; d++) begin
            delay = 10'(d); pluck = 1'b1; tick(); pluck = 1'b0;
            nb = 0;
            for (int k = 0; k < 8; k++) begin tick(); nb += int'(busy); end
            check($sformatf("burst_len_delay%0d", d), nb, 2);
        end

        // decay 128, steady feedback +-1000.
        delay = 10'd3; decay = 8'd128; fb = 24'sd1000;
        pluck = 1'b1; tick(); pluck = 1'b0;
        repeat (6) tick();
        check("ring_pos1000", longint'(out), 500);
        fb = -24'sd1000;
        repeat (2) tick();
        check("ring_neg1000", longint'(out), -500);

        // decay 255: -3 rounds toward zero to -2, -1 decays to silence.
        decay = 8'd255; fb = -24'sd3;
        repeat (2) tick();
        check("ring_neg3", longint'(out), -2);
        fb = -24'sd1;
        repeat (2) tick();
        check("ring_neg1_out", longint'(out), 0);
        check("ring_neg1_active", longint'(active), 1);
        repeat (3) tick();
        check("ring_neg1_idle", longint'(active), 0);

        // bl=4, silent feedback: four zeros then idle.
        fb = 24'sd0; delay = 10'd4;
        pluck = 1'b1; tick(); pluck = 1'b0;
        repeat (4) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("silent%0d_out", k), longint'(out), 0);
            check($sformatf("silent%0d_active", k), longint'(active), 1);
        end
        tick();
        check("silent_idle", longint'(active), 0);

        // Same, but pluck on the fourth ring cycle wins over the exit.
        pluck = 1'b1; tick(); pluck = 1'b0;
        repeat (7) tick();
        pluck = 1'b1; tick(); pluck = 1'b0;
        tick();
        check("repluck_ring_busy", longint'(busy), 1);
        repeat (12) tick();

        // Re-pluck at cnt 2 restarts with the new delay.
        delay = 10'd6; pluck = 1'b1; tick(); pluck = 1'b0;
        repeat (2) tick();
        delay = 10'd3; pluck = 1'b1; tick(); pluck = 1'b0;
        nb = 0;
        for (int k = 0; k < 10; k++) begin tick(); nb += int'(busy); end
        check("repluck_burst_len", nb, 3);

        // pluck held through reset does not trigger.
        pluck = 1'b1; rst_n = 1'b0; tick(); rst_n = 1'b1;
        nb = 0;
        for (int k = 0; k < 4; k++) begin tick(); nb += int'(busy) + int'(active); end
        check("held_pluck_no_burst", nb, 0);
        pluck = 1'b0; tick(); pluck = 1'b1; tick(); tick();
        check("held_pluck_then_edge", longint'(busy), 1);
        tick();

        // Reset mid-burst, next burst starts from the seed again.
        rst_n = 1'b0; tick();
        check("midreset_out", longint'(out), 0);
        check("midreset_busy", longint'(busy), 0);
        rst_n = 1'b1; pluck = 1'b0; level = 3'd0; delay = 10'd5; tick();
        pluck = 1'b1; tick(); pluck = 1'b0; tick();
        check("midreset_seed", longint'(out), longint'(SEED));
        repeat (12) tick();

        // Random stimulus against the model.
        for (int k = 0; k < 4000; k++) begin
            int r;
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 15) == 0) pluck = ~pluck;
            delay = 10'($urandom_range(0, 12));
            decay = 8'($urandom_range(0, 255));
            level = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 9));
            if (r < 5)      fb = 24'($signed(int'($urandom_range(0, 8)) - 4));
            else if (r < 8) fb = 24'($urandom);
            else            fb = 24'sd0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
